// File: rtl/hpm_counter_unit.sv
// Hardware performance monitor: NumCounters event-selectable counters (mhpmcounter3..).
// Optional macro PERF_CNT_OVF_IRQ_EN adds sticky overflow flags (mhpmevent[XLEN-1]) and ovf_irq_o.
module hpm_counter_unit #(
   parameter int unsigned NumCounters = 8,
   parameter int unsigned NumEvents   = 64,
   parameter int unsigned IncWidth    = 2,
   parameter int unsigned CntWidth    = 64,
   parameter int unsigned XLEN        = 64
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          debug_mode_i,
   input  logic [11:0]                   csr_addr_i,
   input  logic                          csr_we_i,
   input  logic                          csr_re_i,
   input  logic [XLEN-1:0]               csr_wdata_i,
   output logic [XLEN-1:0]               csr_rdata_o,
   output logic                          csr_illegal_o,
   input  logic [NumEvents*IncWidth-1:0] evt_inc_i,
   input  logic [31:0]                   mcountinhibit_i,
   output logic                          ovf_irq_o
);
   localparam int unsigned SelWidth = $clog2(NumEvents);
   localparam int unsigned SumWidth = CntWidth + 1;
   localparam bit          Xlen64   = (XLEN == 64);

   logic                in_cnt, in_cnth, in_evt, in_ro, in_roh;
   logic [4:0]          idx;
   logic                illegal, wr_ok;
   logic [63:0]         wdata_ext, sel_val;
   logic [SelWidth-1:0] sel_wr;
   logic [NumCounters-1:0] of_bit;
   logic [XLEN-1:0]     rd_k [NumCounters];
   logic [IncWidth-1:0] inc_arr [NumEvents];

   // Every range starts at low-5-bits 0x03 and ends at 0x1F, so the index is shared.
   always_comb begin
      in_cnt  = (csr_addr_i >= 12'hB03) && (csr_addr_i <= 12'hB1F);
      in_cnth = (csr_addr_i >= 12'hB83) && (csr_addr_i <= 12'hB9F);
      in_evt  = (csr_addr_i >= 12'h323) && (csr_addr_i <= 12'h33F);
      in_ro   = (csr_addr_i >= 12'hC03) && (csr_addr_i <= 12'hC1F);
      in_roh  = (csr_addr_i >= 12'hC83) && (csr_addr_i <= 12'hC9F);
      idx     = csr_addr_i[4:0] - 5'd3;
   end

   always_comb begin
      illegal = (csr_we_i && (in_ro || in_roh))
             || (Xlen64 && (csr_we_i || csr_re_i) && (in_cnth || in_roh));
      if (!rst_ni) begin
         illegal = 1'b0;
      end
      wr_ok = csr_we_i && !illegal;
   end

   assign csr_illegal_o = illegal;
   assign wdata_ext     = 64'(csr_wdata_i);

   // The OF position never takes part in the WARL select range check.
   always_comb begin
      sel_val         = wdata_ext;
      sel_val[XLEN-1] = 1'b0;
      sel_wr          = (sel_val < 64'(NumEvents)) ? sel_val[SelWidth-1:0] : '0;
   end

   for (genvar e = 0; e < NumEvents; e++) begin : g_inc
      assign inc_arr[e] = evt_inc_i[e*IncWidth +: IncWidth];
   end

   for (genvar k = 0; k < NumCounters; k++) begin : g_cnt
      logic                hit, count_en, wrap, of_rd;
      logic [CntWidth-1:0] cnt_q, cnt_d;
      logic [SelWidth-1:0] sel_q, sel_d;
      logic [CntWidth:0]   sum;
      logic [63:0]         cnt_ext, wr_lo, wr_hi;
      logic [XLEN-1:0]     rd_lo, rd_hi, rd_evt;
      logic                unused_blk;

      assign hit      = (idx == 5'(k));
      assign count_en = !debug_mode_i && !mcountinhibit_i[k+3] && (sel_q != '0);
      assign sum      = {1'b0, cnt_q} + SumWidth'(inc_arr[sel_q]);
      assign cnt_ext  = 64'(cnt_q);

      if (XLEN == 64) begin : g_x64
         assign wr_lo = wdata_ext;
         assign wr_hi = cnt_ext;
         assign rd_lo = XLEN'(cnt_ext);
         assign rd_hi = '0;
      end else begin : g_x32
         assign wr_lo = {cnt_ext[63:32], wdata_ext[31:0]};
         assign wr_hi = {wdata_ext[31:0], cnt_ext[31:0]};
         assign rd_lo = XLEN'(cnt_ext[31:0]);
         assign rd_hi = XLEN'(cnt_ext[63:32]);
      end

      // A CSR write to this counter pre-empts its own increment.
      always_comb begin
         cnt_d = cnt_q;
         wrap  = 1'b0;
         if (wr_ok && in_cnt && hit) begin
            cnt_d = wr_lo[CntWidth-1:0];
         end else if (wr_ok && in_cnth && hit) begin
            cnt_d = wr_hi[CntWidth-1:0];
         end else if (count_en) begin
            cnt_d = sum[CntWidth-1:0];
            wrap  = sum[CntWidth];
         end
         sel_d = (wr_ok && in_evt && hit) ? sel_wr : sel_q;
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            cnt_q <= '0;
            sel_q <= '0;
         end else begin
            cnt_q <= cnt_d;
            sel_q <= sel_d;
         end
      end

`ifdef PERF_CNT_OVF_IRQ_EN
      logic of_q, of_d;

      // A software write to mhpmevent beats a wrap in the same cycle.
      always_comb begin
         of_d = of_q;
         if (wr_ok && in_evt && hit) begin
            of_d = csr_wdata_i[XLEN-1];
         end else if (wrap) begin
            of_d = 1'b1;
         end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            of_q <= 1'b0;
         end else begin
            of_q <= of_d;
         end
      end

      assign of_rd = of_q;
`else
      assign of_rd = 1'b0;
`endif
      assign of_bit[k] = of_rd;

      always_comb begin
         rd_evt                = '0;
         rd_evt[SelWidth-1:0]  = sel_q;
         rd_evt[XLEN-1]        = of_rd;
      end

      assign rd_k[k] = !hit                 ? '0    :
                       (in_cnt  || in_ro)   ? rd_lo :
                       (in_cnth || in_roh)  ? rd_hi :
                       in_evt               ? rd_evt : '0;

      assign unused_blk = ^{wr_lo, wr_hi, wrap};
   end

   always_comb begin
      csr_rdata_o = '0;
      for (int k = 0; k < NumCounters; k++) begin
         csr_rdata_o |= rd_k[k];
      end
      if (!csr_re_i || illegal || !rst_ni) begin
         csr_rdata_o = '0;
      end
   end

`ifdef PERF_CNT_OVF_IRQ_EN
   logic irq_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= |of_bit;
      end
   end

   assign ovf_irq_o = irq_q;
`else
   logic unused_of;
   assign unused_of = ^of_bit;
   assign ovf_irq_o = 1'b0;
`endif

   logic unused_inputs;
   assign unused_inputs = ^{mcountinhibit_i, wdata_ext, sel_val};

endmodule

// File: tb/tb_hpm_counter_unit.sv
// Self-checking bench for hpm_counter_unit: CSR decode vector table plus counting,
// write-priority, wrap/overflow and asynchronous reset sequences.
module tb_hpm_counter_unit;
   localparam int unsigned NumEvents = 64;
   localparam int unsigned IncWidth  = 2;
`ifdef PERF_CNT_OVF_IRQ_EN
   localparam bit HasOf = 1'b1;
`else
   localparam bit HasOf = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         debug_mode;
   logic [11:0]  csr_addr;
   logic         csr_we, csr_re;
   logic [63:0]  csr_wdata;
   logic [63:0]  csr_rdata;
   logic         csr_illegal;
   logic [NumEvents*IncWidth-1:0] evt_inc;
   logic [31:0]  mcountinhibit;
   logic         ovf_irq;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [11:0] addr;
      logic        we;
      logic        re;
      logic [63:0] wdata;
      logic [63:0] exp_rd;
      logic        exp_ill;
   } vec_t;

   vec_t vecs[$];

   hpm_counter_unit dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .debug_mode_i    (debug_mode),
      .csr_addr_i      (csr_addr),
      .csr_we_i        (csr_we),
      .csr_re_i        (csr_re),
      .csr_wdata_i     (csr_wdata),
      .csr_rdata_o     (csr_rdata),
      .csr_illegal_o   (csr_illegal),
      .evt_inc_i       (evt_inc),
      .mcountinhibit_i (mcountinhibit),
      .ovf_irq_o       (ovf_irq)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_rd(input string name, input logic [11:0] a, input logic [63:0] exp);
      csr_addr = a;
      csr_re   = 1'b1;
      csr_we   = 1'b0;
      #1;
      check(name, csr_rdata, exp);
      csr_re = 1'b0;
   endtask

   task automatic wr(input logic [11:0] a, input logic [63:0] d);
      csr_addr  = a;
      csr_wdata = d;
      csr_we    = 1'b1;
      cyc();
      csr_we = 1'b0;
   endtask

   task automatic set_evt(input int e, input logic [1:0] v);
      evt_inc[e*IncWidth +: IncWidth] = v;
   endtask

   function automatic void add(input logic [11:0] a, input logic we, input logic re,
                               input logic [63:0] wd, input logic [63:0] er, input logic ei);
      vec_t v;
      v.addr = a; v.we = we; v.re = re; v.wdata = wd; v.exp_rd = er; v.exp_ill = ei;
      vecs.push_back(v);
   endfunction

   initial begin
      // Counting frozen by debug mode throughout the table; sel3=5, sel4=63, cnt4=0x1234 after it.
      add(12'h323, 1, 0, 64'd5,           64'd0,      0);
      add(12'h323, 0, 1, 64'd0,           64'd5,      0);
      add(12'h323, 1, 0, 64'd71,          64'd0,      0);
      add(12'h323, 0, 1, 64'd0,           64'd0,      0);
      add(12'h323, 1, 1, 64'd5,           64'd0,      0);
      add(12'h323, 0, 1, 64'd0,           64'd5,      0);
      add(12'hB04, 1, 0, 64'h1234,        64'd0,      0);
      add(12'hB04, 0, 1, 64'd0,           64'h1234,   0);
      add(12'hC04, 0, 1, 64'd0,           64'h1234,   0);
      add(12'hC04, 1, 0, 64'h99,          64'd0,      1);
      add(12'hB04, 0, 1, 64'd0,           64'h1234,   0);
      add(12'hB84, 0, 1, 64'd0,           64'd0,      1);
      add(12'hB84, 1, 0, 64'd1,           64'd0,      1);
      add(12'hC84, 0, 1, 64'd0,           64'd0,      1);
      add(12'hB0B, 1, 0, 64'h77,          64'd0,      0);
      add(12'hB0B, 0, 1, 64'd0,           64'd0,      0);
      add(12'h32B, 0, 1, 64'd0,           64'd0,      0);
      add(12'h7C0, 0, 1, 64'd0,           64'd0,      0);
      add(12'hB04, 0, 0, 64'd0,           64'd0,      0);
      add(12'h324, 1, 0, 64'd3,           64'd0,      0);
      add(12'h324, 0, 1, 64'd0,           64'd3,      0);
      add(12'h324, 1, 0, 64'd64,          64'd0,      0);
      add(12'h324, 0, 1, 64'd0,           64'd0,      0);
      add(12'h324, 1, 0, 64'd63,          64'd0,      0);
      add(12'h324, 0, 1, 64'd0,           64'd63,     0);
      add(12'h325, 1, 0, 64'h1_0000_0002, 64'd0,      0);
      add(12'h325, 0, 1, 64'd0,           64'd0,      0);
      add(12'hB0A, 1, 0, 64'hABCD,        64'd0,      0);
      add(12'hC0A, 0, 1, 64'd0,           64'hABCD,   0);
      add(12'hB1F, 0, 1, 64'd0,           64'd0,      0);
      add(12'hC03, 1, 1, 64'd5,           64'd0,      1);
      add(12'hC03, 0, 1, 64'd0,           64'd0,      0);

      rst_n = 1'b0; debug_mode = 1'b0; csr_addr = 12'hC03; csr_we = 1'b1; csr_re = 1'b1;
      csr_wdata = '0; evt_inc = '0; mcountinhibit = '0;
      #2;
      check("reset rdata", csr_rdata, 64'd0);
      check("reset illegal", 64'(csr_illegal), 64'd0);
      check("reset ovf_irq", 64'(ovf_irq), 64'd0);
      csr_we = 1'b0; csr_re = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      chk_rd("reset cnt3", 12'hB03, 64'd0);

      debug_mode = 1'b1;
      foreach (vecs[i]) begin
         csr_addr  = vecs[i].addr;
         csr_we    = vecs[i].we;
         csr_re    = vecs[i].re;
         csr_wdata = vecs[i].wdata;
         #1;
         check($sformatf("vec%0d rdata", i), csr_rdata, vecs[i].exp_rd);
         check($sformatf("vec%0d illegal", i), 64'(csr_illegal), 64'(vecs[i].exp_ill));
         cyc();
      end
      csr_we = 1'b0; csr_re = 1'b0;

      // Basic counting: 10 cycles of +2 on event 5.
      debug_mode = 1'b0;
      set_evt(5, 2'd2);
      repeat (10) cyc();
      evt_inc = '0;
      chk_rd("t1 mhpmcounter3", 12'hB03, 64'd20);
      chk_rd("t1 hpmcounter3", 12'hC03, 64'd20);
      chk_rd("t1 cnt4 idle", 12'hB04, 64'h1234);
      chk_rd("t1 cnt7 sel0", 12'hB0A, 64'hABCD);

      // Inhibit and debug freeze, then inhibit of a neighbour only.
      set_evt(5, 2'd2);
      mcountinhibit = 32'h8;
      repeat (5) cyc();
      chk_rd("t2 inhibit", 12'hB03, 64'd20);
      mcountinhibit = '0;
      debug_mode = 1'b1;
      repeat (5) cyc();
      chk_rd("t2 debug", 12'hB03, 64'd20);
      debug_mode = 1'b0;
      mcountinhibit = 32'h10;
      cyc();
      mcountinhibit = '0;
      evt_inc = '0;
      chk_rd("t2 neighbour inhibit", 12'hB03, 64'd22);

      // Counter write pre-empts its own event; others keep counting.
      set_evt(5, 2'd1);
      set_evt(63, 2'd3);
      wr(12'hB04, 64'h55);
      evt_inc = '0;
      chk_rd("t3 cnt4 written", 12'hB04, 64'h55);
      chk_rd("t3 cnt3 counted", 12'hB03, 64'd23);
      set_evt(63, 2'd3);
      cyc();
      evt_inc = '0;
      chk_rd("t3 cnt4 max inc", 12'hB04, 64'h58);

      // Event select write: this cycle counts with the old select.
      set_evt(5, 2'd1);
      set_evt(63, 2'd3);
      wr(12'h323, 64'd63);
      chk_rd("t3 old select", 12'hB03, 64'd24);
      cyc();
      evt_inc = '0;
      chk_rd("t3 new select", 12'hB03, 64'd27);
      chk_rd("t3 cnt4 after two", 12'hB04, 64'h5E);

      // Wrap from all-ones.
      set_evt(63, 2'd1);
      wr(12'hB03, 64'hFFFF_FFFF_FFFF_FFFF);
      evt_inc = '0;
      chk_rd("wrap preload", 12'hB03, 64'hFFFF_FFFF_FFFF_FFFF);
      set_evt(63, 2'd1);
      cyc();
      evt_inc = '0;
      chk_rd("wrap cnt3", 12'hB03, 64'd0);
      chk_rd("wrap evt3 of", 12'h323, HasOf ? 64'h8000_0000_0000_003F : 64'h3F);
      check("wrap irq same cycle", 64'(ovf_irq), 64'd0);
      cyc();
      check("wrap irq next cycle", 64'(ovf_irq), 64'(HasOf));
`ifdef PERF_CNT_OVF_IRQ_EN
      wr(12'h323, 64'h3F);
      chk_rd("of cleared", 12'h323, 64'h3F);
      check("irq still high", 64'(ovf_irq), 64'd1);
      cyc();
      check("irq dropped", 64'(ovf_irq), 64'd0);
      wr(12'h323, 64'h8000_0000_0000_003F);
      chk_rd("of set by write", 12'h323, 64'h8000_0000_0000_003F);
      wr(12'h323, 64'h3F);
`endif

      // Wrap coinciding with an mhpmevent write: the write decides OF.
      wr(12'hB03, 64'hFFFF_FFFF_FFFF_FFFF);
      set_evt(63, 2'd1);
      wr(12'h323, 64'd63);
      evt_inc = '0;
      chk_rd("wrap vs write cnt", 12'hB03, 64'd0);
      chk_rd("wrap vs write of", 12'h323, 64'h3F);

      // Asynchronous reset mid-count.
`ifdef PERF_CNT_OVF_IRQ_EN
      wr(12'h324, 64'h8000_0000_0000_003F);
      cyc();
      check("pre-reset irq", 64'(ovf_irq), 64'd1);
`endif
      set_evt(5, 2'd2);
      set_evt(63, 2'd3);
      wr(12'h323, 64'd5);
      cyc();
      #2;
      rst_n = 1'b0;
      #1;
      check("async reset irq", 64'(ovf_irq), 64'd0);
      chk_rd("async reset rdata", 12'hB04, 64'd0);
      evt_inc = '0;
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      chk_rd("post reset cnt3", 12'hB03, 64'd0);
      chk_rd("post reset cnt4", 12'hB04, 64'd0);
      chk_rd("post reset cnt7", 12'hB0A, 64'd0);
      chk_rd("post reset evt3", 12'h323, 64'd0);
      chk_rd("post reset evt4", 12'h324, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
